// File: rtl/axi_reg_bank_pkg.sv
// Shared encodings for the register-bank AXI4-Lite arbiter and its register bank.
package axi_reg_bank_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_XFER = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: on a tie the requester that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = (&req) ? ~last : req[1];
    grant  = '0;
    if (|req) grant = gnt_id ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/axi_reg_bank_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter; one read or write in flight, round-robin between masters.
module axi_reg_bank_arbiter
  import axi_reg_bank_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                              s_axi_clk,
  input  logic                              s_axi_rstn,

  input  logic                              s0_axi_AWVALID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s0_axi_AWADDR,
  input  logic                              s0_axi_WVALID,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s0_axi_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s0_axi_WSTRB,
  input  logic                              s0_axi_BREADY,
  input  logic                              s0_axi_ARVALID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s0_axi_ARADDR,
  input  logic                              s0_axi_RREADY,
  output logic                              s0_axi_AWREADY,
  output logic                              s0_axi_WREADY,
  output logic                              s0_axi_BVALID,
  output logic [1:0]                        s0_axi_BRESP,
  output logic                              s0_axi_ARREADY,
  output logic                              s0_axi_RVALID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s0_axi_RDATA,
  output logic [1:0]                        s0_axi_RRESP,

  input  logic                              s1_axi_AWVALID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s1_axi_AWADDR,
  input  logic                              s1_axi_WVALID,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s1_axi_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s1_axi_WSTRB,
  input  logic                              s1_axi_BREADY,
  input  logic                              s1_axi_ARVALID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s1_axi_ARADDR,
  input  logic                              s1_axi_RREADY,
  output logic                              s1_axi_AWREADY,
  output logic                              s1_axi_WREADY,
  output logic                              s1_axi_BVALID,
  output logic [1:0]                        s1_axi_BRESP,
  output logic                              s1_axi_ARREADY,
  output logic                              s1_axi_RVALID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s1_axi_RDATA,
  output logic [1:0]                        s1_axi_RRESP,

  output logic                              m_axi_AWVALID,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     m_axi_AWADDR,
  output logic                              m_axi_WVALID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     m_axi_WDATA,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   m_axi_WSTRB,
  output logic                              m_axi_BREADY,
  output logic                              m_axi_ARVALID,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     m_axi_ARADDR,
  output logic                              m_axi_RREADY,
  input  logic                              m_axi_AWREADY,
  input  logic                              m_axi_WREADY,
  input  logic                              m_axi_BVALID,
  input  logic [1:0]                        m_axi_BRESP,
  input  logic                              m_axi_ARREADY,
  input  logic                              m_axi_RVALID,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     m_axi_RDATA,
  input  logic [1:0]                        m_axi_RRESP,

  output logic                              grant_id,
  output logic                              busy
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [1:0]                    mst_awvalid, mst_wvalid, mst_bready, mst_arvalid, mst_rready;
  logic [C_S_AXI_ADDR_WIDTH-1:0] mst_awaddr [2];
  logic [C_S_AXI_ADDR_WIDTH-1:0] mst_araddr [2];
  logic [C_S_AXI_DATA_WIDTH-1:0] mst_wdata  [2];
  logic [STRB_W-1:0]             mst_wstrb  [2];

  logic [2:0] state;
  logic       last_grant;
  logic       aw_done, w_done;

  logic [1:0] req_rd, req_wr, arb_grant;
  logic       arb_id;
  logic       st_rd_addr, st_rd_data, st_wr_xfer, st_wr_resp;
  logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [1:0] sel;
  logic [1:0] up_awready, up_wready, up_bvalid, up_arready, up_rvalid;

  assign mst_awvalid   = {s1_axi_AWVALID, s0_axi_AWVALID};
  assign mst_wvalid    = {s1_axi_WVALID,  s0_axi_WVALID};
  assign mst_bready    = {s1_axi_BREADY,  s0_axi_BREADY};
  assign mst_arvalid   = {s1_axi_ARVALID, s0_axi_ARVALID};
  assign mst_rready    = {s1_axi_RREADY,  s0_axi_RREADY};
  assign mst_awaddr[0] = s0_axi_AWADDR;
  assign mst_awaddr[1] = s1_axi_AWADDR;
  assign mst_araddr[0] = s0_axi_ARADDR;
  assign mst_araddr[1] = s1_axi_ARADDR;
  assign mst_wdata[0]  = s0_axi_WDATA;
  assign mst_wdata[1]  = s1_axi_WDATA;
  assign mst_wstrb[0]  = s0_axi_WSTRB;
  assign mst_wstrb[1]  = s1_axi_WSTRB;

  assign req_rd = mst_arvalid;
  assign req_wr = mst_awvalid & mst_wvalid;

  rr_arb2 u_rr_arb2 (
    .req    (req_rd | req_wr),
    .last   (last_grant),
    .grant  (arb_grant),
    .gnt_id (arb_id)
  );

  assign st_rd_addr = (state == RD_ADDR);
  assign st_rd_data = (state == RD_DATA);
  assign st_wr_xfer = (state == WR_XFER);
  assign st_wr_resp = (state == WR_RESP);
  assign busy       = (state != IDLE);
  assign sel        = grant_id ? 2'b10 : 2'b01;

  // Downstream side: only the granted master's channels, gated by the phase that owns them.
  assign m_axi_ARVALID = st_rd_addr & mst_arvalid[grant_id];
  assign m_axi_ARADDR  = mst_araddr[grant_id];
  assign m_axi_RREADY  = st_rd_data & mst_rready[grant_id];
  assign m_axi_AWVALID = st_wr_xfer & ~aw_done & mst_awvalid[grant_id];
  assign m_axi_AWADDR  = mst_awaddr[grant_id];
  assign m_axi_WVALID  = st_wr_xfer & ~w_done & mst_wvalid[grant_id];
  assign m_axi_WDATA   = mst_wdata[grant_id];
  assign m_axi_WSTRB   = mst_wstrb[grant_id];
  assign m_axi_BREADY  = st_wr_resp & mst_bready[grant_id];

  assign ar_hs = m_axi_ARVALID & m_axi_ARREADY;
  assign r_hs  = m_axi_RVALID  & m_axi_RREADY;
  assign aw_hs = m_axi_AWVALID & m_axi_AWREADY;
  assign w_hs  = m_axi_WVALID  & m_axi_WREADY;
  assign b_hs  = m_axi_BVALID  & m_axi_BREADY;

  assign up_arready = sel & {2{st_rd_addr & m_axi_ARREADY}};
  assign up_rvalid  = sel & {2{st_rd_data & m_axi_RVALID}};
  assign up_awready = sel & {2{st_wr_xfer & ~aw_done & m_axi_AWREADY}};
  assign up_wready  = sel & {2{st_wr_xfer & ~w_done & m_axi_WREADY}};
  assign up_bvalid  = sel & {2{st_wr_resp & m_axi_BVALID}};

  assign s0_axi_ARREADY = up_arready[0];
  assign s0_axi_RVALID  = up_rvalid[0];
  assign s0_axi_RDATA   = up_rvalid[0] ? m_axi_RDATA : '0;
  assign s0_axi_RRESP   = up_rvalid[0] ? m_axi_RRESP : RESP_OKAY;
  assign s0_axi_AWREADY = up_awready[0];
  assign s0_axi_WREADY  = up_wready[0];
  assign s0_axi_BVALID  = up_bvalid[0];
  assign s0_axi_BRESP   = up_bvalid[0] ? m_axi_BRESP : RESP_OKAY;

  assign s1_axi_ARREADY = up_arready[1];
  assign s1_axi_RVALID  = up_rvalid[1];
  assign s1_axi_RDATA   = up_rvalid[1] ? m_axi_RDATA : '0;
  assign s1_axi_RRESP   = up_rvalid[1] ? m_axi_RRESP : RESP_OKAY;
  assign s1_axi_AWREADY = up_awready[1];
  assign s1_axi_WREADY  = up_wready[1];
  assign s1_axi_BVALID  = up_bvalid[1];
  assign s1_axi_BRESP   = up_bvalid[1] ? m_axi_BRESP : RESP_OKAY;

  always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
    if (!s_axi_rstn) begin
      state      <= IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|arb_grant) begin
            grant_id <= arb_id;
            state    <= req_rd[arb_id] ? RD_ADDR : WR_XFER;
          end
        end
        RD_ADDR: if (ar_hs) state <= RD_DATA;
        RD_DATA: begin
          if (r_hs) begin
            state      <= IDLE;
            last_grant <= grant_id;
          end
        end
        WR_XFER: begin
          // AW and W may complete in either order or together; leave once both have.
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            state      <= IDLE;
            last_grant <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_reg_bank_arbiter.sv
// Directed bench for axi_reg_bank_arbiter with a small register-bank slave model.
module tb_axi_reg_bank_arbiter;

  localparam int BUDGET = 60;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
  logic [4:0]  awaddr [2];
  logic [4:0]  araddr [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic [1:0]  awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp  [2];
  logic [1:0]  rresp  [2];
  logic [31:0] rdata  [2];

  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [4:0]  m_awaddr, m_araddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        grant_id, busy;

  int n_checks = 0;
  int n_fail   = 0;

  axi_reg_bank_arbiter #(.C_S_AXI_ADDR_WIDTH(5), .C_S_AXI_DATA_WIDTH(32)) dut (
    .s_axi_clk(clk), .s_axi_rstn(rstn),
    .s0_axi_AWVALID(awvalid[0]), .s0_axi_AWADDR(awaddr[0]), .s0_axi_WVALID(wvalid[0]),
    .s0_axi_WDATA(wdata[0]), .s0_axi_WSTRB(wstrb[0]), .s0_axi_BREADY(bready[0]),
    .s0_axi_ARVALID(arvalid[0]), .s0_axi_ARADDR(araddr[0]), .s0_axi_RREADY(rready[0]),
    .s0_axi_AWREADY(awready[0]), .s0_axi_WREADY(wready[0]), .s0_axi_BVALID(bvalid[0]),
    .s0_axi_BRESP(bresp[0]), .s0_axi_ARREADY(arready[0]), .s0_axi_RVALID(rvalid[0]),
    .s0_axi_RDATA(rdata[0]), .s0_axi_RRESP(rresp[0]),
    .s1_axi_AWVALID(awvalid[1]), .s1_axi_AWADDR(awaddr[1]), .s1_axi_WVALID(wvalid[1]),
    .s1_axi_WDATA(wdata[1]), .s1_axi_WSTRB(wstrb[1]), .s1_axi_BREADY(bready[1]),
    .s1_axi_ARVALID(arvalid[1]), .s1_axi_ARADDR(araddr[1]), .s1_axi_RREADY(rready[1]),
    .s1_axi_AWREADY(awready[1]), .s1_axi_WREADY(wready[1]), .s1_axi_BVALID(bvalid[1]),
    .s1_axi_BRESP(bresp[1]), .s1_axi_ARREADY(arready[1]), .s1_axi_RVALID(rvalid[1]),
    .s1_axi_RDATA(rdata[1]), .s1_axi_RRESP(rresp[1]),
    .m_axi_AWVALID(m_awvalid), .m_axi_AWADDR(m_awaddr), .m_axi_WVALID(m_wvalid),
    .m_axi_WDATA(m_wdata), .m_axi_WSTRB(m_wstrb), .m_axi_BREADY(m_bready),
    .m_axi_ARVALID(m_arvalid), .m_axi_ARADDR(m_araddr), .m_axi_RREADY(m_rready),
    .m_axi_AWREADY(m_awready), .m_axi_WREADY(m_wready), .m_axi_BVALID(m_bvalid),
    .m_axi_BRESP(m_bresp), .m_axi_ARREADY(m_arready), .m_axi_RVALID(m_rvalid),
    .m_axi_RDATA(m_rdata), .m_axi_RRESP(m_rresp),
    .grant_id(grant_id), .busy(busy)
  );

  // ---------------- register-bank slave model ----------------
  int ar_delay, aw_delay, w_delay;
  logic [1:0] slv_rresp, slv_bresp;
  int ar_cnt, aw_cnt, w_cnt;
  logic aw_got, w_got;
  int cyc = 0, aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, aw_cyc = 0, w_cyc = 0;
  logic [4:0]  log_addr = '0;
  logic [31:0] log_data = '0;
  logic [3:0]  log_strb = '0;

  function automatic logic [31:0] slave_word(input logic [4:0] a);
    return (a == 5'h08) ? 32'hDEADBEEF : {24'hA5A5A5, 3'b000, a};
  endfunction

  assign m_arready = m_arvalid && (ar_cnt >= ar_delay);
  assign m_awready = m_awvalid && (aw_cnt >= aw_delay);
  assign m_wready  = m_wvalid  && (w_cnt  >= w_delay);

  wire s_aw_hs = m_awvalid && m_awready;
  wire s_w_hs  = m_wvalid  && m_wready;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
      m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
      m_bvalid <= 1'b0; m_bresp <= '0; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid  && !m_wready)  ? w_cnt + 1  : 0;
      if (m_rvalid && m_rready) begin
        m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
      end
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1; m_rdata <= slave_word(m_araddr); m_rresp <= slv_rresp;
      end
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0; m_bresp <= '0;
      end
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        m_bvalid <= 1'b1; m_bresp <= slv_bresp; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (s_aw_hs) aw_got <= 1'b1;
        if (s_w_hs)  w_got  <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_aw_hs) begin aw_hs_cnt <= aw_hs_cnt + 1; aw_cyc <= cyc; log_addr <= m_awaddr; end
    if (s_w_hs)  begin w_hs_cnt <= w_hs_cnt + 1; w_cyc <= cyc; log_data <= m_wdata; log_strb <= m_wstrb; end
    if (m_bvalid && m_bready) b_hs_cnt <= b_hs_cnt + 1;
  end

  // ---------------- transaction monitor ----------------
  logic grant_log[$];
  logic kind_log[$];
  int   gap_log[$];
  logic busy_q = 1'b0;
  int   idle_run = 0, busy_cycles = 0, s1_act = 0;

  always begin
    @(negedge clk);
    #2;
    if (busy && !busy_q) begin
      grant_log.push_back(grant_id);
      kind_log.push_back(!m_arvalid);
      gap_log.push_back(idle_run);
    end
    if (busy) busy_cycles++;
    idle_run = busy ? 0 : idle_run + 1;
    busy_q = busy;
    if (arready[1] | rvalid[1] | awready[1] | wready[1] | bvalid[1]) s1_act++;
  end

  // ---------------- master drivers ----------------
  task automatic m_read(input int m, input logic [4:0] addr,
                        output logic [31:0] data, output logic [1:0] resp, output bit ok);
    int n;
    ok = 0; data = '0; resp = '0; n = 0;
    @(negedge clk);
    arvalid[m] = 1'b1; araddr[m] = addr; rready[m] = 1'b1;
    while (n < BUDGET) begin
      #1; if (arready[m]) break;
      @(negedge clk); n++;
    end
    @(negedge clk);
    arvalid[m] = 1'b0;
    if (n >= BUDGET) begin rready[m] = 1'b0; return; end
    while (n < BUDGET) begin
      #1; if (rvalid[m]) break;
      @(negedge clk); n++;
    end
    if (n < BUDGET) begin data = rdata[m]; resp = rresp[m]; ok = 1; end
    @(negedge clk);
    rready[m] = 1'b0;
  endtask

  task automatic m_write(input int m, input logic [4:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [1:0] resp, output bit ok);
    int n;
    bit aw_pend, w_pend, aw_hit, w_hit;
    ok = 0; resp = '0; n = 0; aw_pend = 1; w_pend = 1;
    @(negedge clk);
    awvalid[m] = 1'b1; awaddr[m] = addr; wvalid[m] = 1'b1;
    wdata[m] = data; wstrb[m] = strb; bready[m] = 1'b1;
    while ((aw_pend || w_pend) && n < BUDGET) begin
      #1;
      aw_hit = aw_pend && awready[m];
      w_hit  = w_pend && wready[m];
      @(negedge clk); n++;
      if (aw_hit) begin awvalid[m] = 1'b0; aw_pend = 0; end
      if (w_hit)  begin wvalid[m]  = 1'b0; w_pend  = 0; end
    end
    if (aw_pend || w_pend) begin
      awvalid[m] = 1'b0; wvalid[m] = 1'b0; bready[m] = 1'b0; return;
    end
    while (n < BUDGET) begin
      #1; if (bvalid[m]) break;
      @(negedge clk); n++;
    end
    if (n < BUDGET) begin resp = bresp[m]; ok = 1; end
    @(negedge clk);
    bready[m] = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; araddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    ar_delay = 0; aw_delay = 0; w_delay = 0; slv_rresp = 2'b00; slv_bresp = 2'b00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id: got %b expected 0", grant_id); end
    n_checks++;
    if ({arready, rvalid, awready, wready, bvalid, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_handshakes: got %b expected all zero",
               {arready, rvalid, awready, wready, bvalid, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready});
    end
  endtask

  task automatic test_single_read();
    logic [31:0] d; logic [1:0] r; bit ok; int b0, a0;
    do_reset();
    ar_delay = 1;
    b0 = busy_cycles; a0 = s1_act;
    m_read(0, 5'h08, d, r, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL single_read_done: got %b expected 1", ok); end
    n_checks++;
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_read_data: got %h expected deadbeef", d); end
    n_checks++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL single_read_resp: got %b expected 00", r); end
    n_checks++;
    if (busy_cycles - b0 != 3) begin n_fail++; $display("FAIL single_read_busy_cycles: got %0d expected 3", busy_cycles - b0); end
    n_checks++;
    if (s1_act - a0 != 0) begin n_fail++; $display("FAIL single_read_m1_quiet: got %0d active cycles expected 0", s1_act - a0); end
    n_checks++;
    if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL single_read_rdata_idle: got %h expected 0", rdata[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0a, d0b, d1a, d1b; logic [1:0] r0a, r0b, r1a, r1b;
    bit ok0a, ok0b, ok1a, ok1b; int g0;
    logic exp_g [4];
    do_reset();
    slv_rresp = 2'b10;
    g0 = grant_log.size();
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
    fork
      begin m_read(0, 5'h04, d0a, r0a, ok0a); m_read(0, 5'h04, d0b, r0b, ok0b); end
      begin m_read(1, 5'h0C, d1a, r1a, ok1a); m_read(1, 5'h0C, d1b, r1b, ok1b); end
    join
    n_checks++;
    if ({ok0a, ok0b, ok1a, ok1b} !== 4'b1111) begin n_fail++; $display("FAIL b2b_done: got %b expected 1111", {ok0a, ok0b, ok1a, ok1b}); end
    n_checks++;
    if (d1b !== 32'hA5A5A50C) begin n_fail++; $display("FAIL b2b_m1_data: got %h expected a5a5a50c", d1b); end
    n_checks++;
    if (d0a !== 32'hA5A5A504) begin n_fail++; $display("FAIL b2b_m0_data: got %h expected a5a5a504", d0a); end
    n_checks++;
    if ({r0a, r0b, r1a, r1b} !== 8'b10101010) begin n_fail++; $display("FAIL b2b_rresp_passthru: got %b expected 10101010", {r0a, r0b, r1a, r1b}); end
    n_checks++;
    if (grant_log.size() != g0 + 4) begin
      n_fail++; $display("FAIL b2b_txn_count: got %0d expected 4", grant_log.size() - g0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (grant_log[g0+i] !== exp_g[i]) begin n_fail++; $display("FAIL b2b_grant_%0d: got %b expected %b", i, grant_log[g0+i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_write_split();
    logic [1:0] r; bit ok; int aw0, w0, b0, g0;
    do_reset();
    aw_delay = 2; w_delay = 0;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt; g0 = grant_log.size();
    m_write(1, 5'h10, 32'h12345678, 4'hF, r, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL write_done: got %b expected 1", ok); end
    n_checks++;
    if (aw_hs_cnt - aw0 != 1) begin n_fail++; $display("FAIL write_aw_count: got %0d expected 1", aw_hs_cnt - aw0); end
    n_checks++;
    if (w_hs_cnt - w0 != 1) begin n_fail++; $display("FAIL write_w_count: got %0d expected 1", w_hs_cnt - w0); end
    n_checks++;
    if (b_hs_cnt - b0 != 1) begin n_fail++; $display("FAIL write_b_count: got %0d expected 1", b_hs_cnt - b0); end
    n_checks++;
    if (aw_cyc - w_cyc != 2) begin n_fail++; $display("FAIL write_w_lead: got %0d expected 2", aw_cyc - w_cyc); end
    n_checks++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL write_bresp: got %b expected 00", r); end
    n_checks++;
    if ({log_addr, log_data, log_strb} !== {5'h10, 32'h12345678, 4'hF}) begin
      n_fail++; $display("FAIL write_payload: got %h/%h/%h expected 10/12345678/f", log_addr, log_data, log_strb);
    end
    n_checks++;
    if (grant_log.size() != g0 + 1 || grant_log[grant_log.size()-1] !== 1'b1) begin
      n_fail++; $display("FAIL write_grant: got %0d txns expected 1 txn to master 1", grant_log.size() - g0);
    end
  endtask

  task automatic test_read_beats_write();
    logic [31:0] d; logic [1:0] rr, br; bit okr, okw; int g0;
    do_reset();
    slv_bresp = 2'b10;
    g0 = grant_log.size();
    fork
      m_read(0, 5'h14, d, rr, okr);
      m_write(0, 5'h18, 32'hCAFEF00D, 4'h3, br, okw);
    join
    repeat (2) @(negedge clk);
    n_checks++;
    if ({okr, okw} !== 2'b11) begin n_fail++; $display("FAIL rbw_done: got %b expected 11", {okr, okw}); end
    n_checks++;
    if (d !== 32'hA5A5A514) begin n_fail++; $display("FAIL rbw_read_data: got %h expected a5a5a514", d); end
    n_checks++;
    if (br !== 2'b10) begin n_fail++; $display("FAIL rbw_bresp_passthru: got %b expected 10", br); end
    n_checks++;
    if (kind_log.size() != g0 + 2) begin
      n_fail++; $display("FAIL rbw_txn_count: got %0d expected 2", kind_log.size() - g0);
    end else begin
      n_checks++;
      if ({kind_log[g0], kind_log[g0+1]} !== 2'b01) begin
        n_fail++; $display("FAIL rbw_order: got %b expected 01 (read then write)", {kind_log[g0], kind_log[g0+1]});
      end
      n_checks++;
      if (gap_log[g0+1] != 1) begin n_fail++; $display("FAIL rbw_idle_gap: got %0d expected 1", gap_log[g0+1]); end
    end
  endtask

  task automatic test_rready_hold();
    logic [31:0] d1; logic [1:0] r1; bit ok1; int g0, n; bit seen;
    do_reset();
    g0 = grant_log.size();
    fork
      m_read(1, 5'h1C, d1, r1, ok1);
      begin
        @(negedge clk);
        arvalid[0] = 1'b1; araddr[0] = 5'h08; rready[0] = 1'b0;
        n = 0;
        while (n < BUDGET) begin #1; if (arready[0]) break; @(negedge clk); n++; end
        @(negedge clk);
        arvalid[0] = 1'b0;
        seen = 0;
        while (n < BUDGET) begin #1; if (rvalid[0]) begin seen = 1; break; end @(negedge clk); n++; end
        n_checks++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL hold_rvalid_seen: got %b expected 1", seen); end
        for (int i = 0; i < 5; i++) begin
          n_checks++;
          if ({rvalid[0], rdata[0], arready[1]} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_stable_%0d: got rvalid=%b rdata=%h m1_arready=%b expected 1/deadbeef/0",
                     i, rvalid[0], rdata[0], arready[1]);
          end
          @(negedge clk); #1;
        end
        rready[0] = 1'b1;
        @(negedge clk);
        rready[0] = 1'b0;
      end
    join
    n_checks++;
    if (ok1 !== 1'b1 || d1 !== 32'hA5A5A51C) begin n_fail++; $display("FAIL hold_m1_read: got ok=%b data=%h expected 1/a5a5a51c", ok1, d1); end
    n_checks++;
    if (grant_log.size() != g0 + 2 || grant_log[g0] !== 1'b0 || grant_log[g0+1] !== 1'b1) begin
      n_fail++; $display("FAIL hold_grant_order: got %0d txns expected grants 0 then 1", grant_log.size() - g0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit ok, seen; int n;
    do_reset();
    @(negedge clk);
    arvalid[0] = 1'b1; araddr[0] = 5'h08; rready[0] = 1'b0;
    n = 0;
    while (n < BUDGET) begin #1; if (arready[0]) break; @(negedge clk); n++; end
    @(negedge clk);
    arvalid[0] = 1'b0;
    seen = 0;
    while (n < BUDGET) begin #1; if (rvalid[0]) begin seen = 1; break; end @(negedge clk); n++; end
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_rd_data: got %b expected 1", seen); end
    #1;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, grant_id} !== 2'b00) begin n_fail++; $display("FAIL rstmid_busy_grant: got %b expected 00", {busy, grant_id}); end
    n_checks++;
    if ({arready, rvalid, awready, wready, bvalid, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 15'd0) begin
      n_fail++;
      $display("FAIL rstmid_handshakes: got %b expected all zero",
               {arready, rvalid, awready, wready, bvalid, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready});
    end
    n_checks++;
    if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 0", rdata[0]); end
    @(negedge clk);
    rstn = 1'b1;
    m_read(1, 5'h0C, d, r, ok);
    n_checks++;
    if (ok !== 1'b1 || d !== 32'hA5A5A50C || r !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_fresh_read: got ok=%b data=%h resp=%b expected 1/a5a5a50c/00", ok, d, r);
    end
    n_checks++;
    if (grant_log[grant_log.size()-1] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_fresh_grant: got %b expected 1", grant_log[grant_log.size()-1]);
    end
  endtask

  initial begin
    rstn = 1'b0;
    awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; araddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    ar_delay = 0; aw_delay = 0; w_delay = 0; slv_rresp = 2'b00; slv_bresp = 2'b00;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_split();
    test_read_beats_write();
    test_rready_hold();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
